// File: rtl/sobel_grad_if.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_grad_if
//  Description : Bundle of the pixel-stream input and the gradient output of
//                the 3x3 Sobel gradient stage.
//                  pix_in/pix_valid/sof        : raster-order pixel stream
//                  sobel_x/sobel_y             : signed 9-bit scaled gradients
//                  grad_valid/grad_addr        : output qualifier + centre address
//                  frame_done                  : end-of-frame pulse
//                master : pixel source / gradient consumer
//                slave  : the gradient stage itself
//  Revision    : 1.0  initial release
// ============================================================================
interface sobel_grad_if #(
    parameter int PIXW = 24
);
    logic [7:0]        pix_in;
    logic              pix_valid;
    logic              sof;
    logic signed [8:0] sobel_x;
    logic signed [8:0] sobel_y;
    logic              grad_valid;
    logic [PIXW-1:0]   grad_addr;
    logic              frame_done;

    modport master (
        output pix_in,
        output pix_valid,
        output sof,
        input  sobel_x,
        input  sobel_y,
        input  grad_valid,
        input  grad_addr,
        input  frame_done
    );

    modport slave (
        input  pix_in,
        input  pix_valid,
        input  sof,
        output sobel_x,
        output sobel_y,
        output grad_valid,
        output grad_addr,
        output frame_done
    );
endinterface
`default_nettype wire

// File: rtl/sobel_grad.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_grad
//  Description : Streaming 3x3 Sobel gradient stage. Accepts raster-order
//                8-bit pixels, keeps two line buffers and a 3x3 window, and
//                for every interior pixel emits signed 9-bit horizontal and
//                vertical gradients (full gradient >>> 2) with the linear
//                address of the window centre.
//  Ports       : clk        - clock, rising edge
//                reset      - synchronous, active-high
//                bus.slave  - pix_in/pix_valid/sof in,
//                             sobel_x/sobel_y/grad_valid/grad_addr/frame_done out
//  Pipeline    : stage 1 - counters, line buffers, window, valid flag,
//                          centre address, frame_done
//                stage 2 - gradients, grad_valid, grad_addr
//  Revision    : 1.0  initial release
// ============================================================================
module sobel_grad #(
    parameter int IMG_W = 1024,
    parameter int IMG_H = 512,
    parameter int PIXW  = 24
) (
    input  logic        clk,
    input  logic        reset,
    sobel_grad_if.slave bus
);

    localparam int c_COLW = $clog2(IMG_W);
    localparam int c_ROWW = $clog2(IMG_H);

    localparam logic [c_COLW-1:0] c_LAST_COL = c_COLW'(IMG_W - 1);
    localparam logic [c_ROWW-1:0] c_LAST_ROW = c_ROWW'(IMG_H - 1);
    // The newest pixel sits at the bottom-right of the window, so the centre
    // is one row up and one column left of it.
    localparam logic [PIXW-1:0]   c_CTR_OFS  = PIXW'(IMG_W + 1);

    // ------------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------------
    logic [c_COLW-1:0] r_col;
    logic [c_ROWW-1:0] r_row;
    logic [PIXW-1:0]   r_addr;

    // Effective position of the pixel on the bus: sof forces (0,0) no matter
    // where the counters currently are.
    logic [c_COLW-1:0] w_col;
    logic [c_ROWW-1:0] w_row;
    logic [PIXW-1:0]   w_addr;

    logic [c_COLW-1:0] w_col_nxt;
    logic [c_ROWW-1:0] w_row_nxt;
    logic [PIXW-1:0]   w_addr_nxt;

    logic              w_col_last;
    logic              w_row_last;
    logic              w_frame_end;
    logic              w_interior;

    always_comb begin
        w_col  = r_col;
        w_row  = r_row;
        w_addr = r_addr;
        if (bus.sof) begin
            w_col  = '0;
            w_row  = '0;
            w_addr = '0;
        end
    end

    assign w_col_last  = (w_col == c_LAST_COL);
    assign w_row_last  = (w_row == c_LAST_ROW);
    // A resync pixel is never the end of a frame, even if the counters
    // happened to point at the last position.
    assign w_frame_end = w_col_last && w_row_last && !bus.sof;
    // Only windows lying entirely inside the current row band produce output;
    // this also rejects windows that straddle a row wrap.
    assign w_interior  = (w_row >= c_ROWW'(2)) && (w_col >= c_COLW'(2));

    always_comb begin
        w_col_nxt  = w_col + c_COLW'(1);
        w_row_nxt  = w_row;
        w_addr_nxt = w_addr + PIXW'(1);
        if (w_col_last) begin
            w_col_nxt = '0;
            if (w_row_last) begin
                w_row_nxt  = '0;
                w_addr_nxt = '0;
            end else begin
                w_row_nxt  = w_row + c_ROWW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1 control: counters, valid flag, centre address, frame end
    // ------------------------------------------------------------------------
    logic            r_s1_valid;
    logic [PIXW-1:0] r_s1_addr;
    logic            r_s1_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_addr     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_last  <= 1'b0;
        end else begin
            // Flags fall on idle cycles so a stall shows up as a single gap
            // at the output rather than a repeated result.
            r_s1_valid <= bus.pix_valid && w_interior;
            r_s1_last  <= bus.pix_valid && w_frame_end;
            if (bus.pix_valid) begin
                r_col     <= w_col_nxt;
                r_row     <= w_row_nxt;
                r_addr    <= w_addr_nxt;
                r_s1_addr <= w_addr - c_CTR_OFS;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Line buffers and 3x3 window (data path, intentionally not reset)
    //   r_lb1 holds row r-1, r_lb2 holds row r-2 at each column.
    //   r_win[i][j]: i=0 top row, j=2 newest column.
    // ------------------------------------------------------------------------
    logic [7:0] r_lb1 [IMG_W];
    logic [7:0] r_lb2 [IMG_W];
    logic [7:0] r_win [3][3];

    logic [7:0] w_lb1_rd;
    logic [7:0] w_lb2_rd;

    assign w_lb1_rd = r_lb1[w_col];
    assign w_lb2_rd = r_lb2[w_col];

    always_ff @(posedge clk) begin
        // Reset has priority: a pixel presented during reset is discarded
        // and must not disturb stored rows.
        if (!reset && bus.pix_valid) begin
            r_lb2[w_col] <= w_lb1_rd;
            r_lb1[w_col] <= bus.pix_in;
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_lb2_rd;
            r_win[1][2] <= w_lb1_rd;
            r_win[2][2] <= bus.pix_in;
        end
    end

    // ------------------------------------------------------------------------
    // Gradients from the stage-1 window. Each weighted column sum is at most
    // 4*255 = 1020, so both operands are non-negative in 11-bit signed and
    // the difference cannot overflow.
    // ------------------------------------------------------------------------
    logic [10:0]        w_sum_right;
    logic [10:0]        w_sum_left;
    logic [10:0]        w_sum_bottom;
    logic [10:0]        w_sum_top;
    logic signed [10:0] w_gx;
    logic signed [10:0] w_gy;

    assign w_sum_right  = {3'b000, r_win[0][2]} + {2'b00, r_win[1][2], 1'b0} + {3'b000, r_win[2][2]};
    assign w_sum_left   = {3'b000, r_win[0][0]} + {2'b00, r_win[1][0], 1'b0} + {3'b000, r_win[2][0]};
    assign w_sum_bottom = {3'b000, r_win[2][0]} + {2'b00, r_win[2][1], 1'b0} + {3'b000, r_win[2][2]};
    assign w_sum_top    = {3'b000, r_win[0][0]} + {2'b00, r_win[0][1], 1'b0} + {3'b000, r_win[0][2]};

    assign w_gx = $signed(w_sum_right)  - $signed(w_sum_left);
    assign w_gy = $signed(w_sum_bottom) - $signed(w_sum_top);

    // ------------------------------------------------------------------------
    // Stage 2 output registers. Dropping the two LSBs of a two's-complement
    // value is an arithmetic shift with floor rounding.
    // ------------------------------------------------------------------------
    logic signed [8:0] r_sobel_x;
    logic signed [8:0] r_sobel_y;
    logic              r_grad_valid;
    logic [PIXW-1:0]   r_grad_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sobel_x    <= '0;
            r_sobel_y    <= '0;
            r_grad_valid <= 1'b0;
            r_grad_addr  <= '0;
        end else begin
            r_grad_valid <= r_s1_valid;
            // Data holds its last value while invalid to avoid needless toggling.
            if (r_s1_valid) begin
                r_sobel_x   <= w_gx[10:2];
                r_sobel_y   <= w_gy[10:2];
                r_grad_addr <= r_s1_addr;
            end
        end
    end

    assign bus.sobel_x    = r_sobel_x;
    assign bus.sobel_y    = r_sobel_y;
    assign bus.grad_valid = r_grad_valid;
    assign bus.grad_addr  = r_grad_addr;
    // frame_done leads the last pixel's grad_valid by one cycle.
    assign bus.frame_done = r_s1_last;

endmodule
`default_nettype wire

// File: tb/tb_sobel_grad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_grad
//  Description : Self-checking bench for sobel_grad on an 8x6 image. Stimulus
//                frames are fed through sobel_grad_if; a reference model
//                computes Sobel gradients directly on a stored image and
//                predicts the cycle of every output and frame_done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sobel_grad;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PW = 24;

    typedef struct packed {
        logic [31:0]   t;
        logic [8:0]    x;
        logic [8:0]    y;
        logic [PW-1:0] a;
    } out_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sobel_grad_if #(.PIXW(PW)) bus ();

    sobel_grad #(.IMG_W(W), .IMG_H(H), .PIXW(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    out_t obs_q[$];
    out_t exp_q[$];
    int   fd_obs_q[$];
    int   fd_exp_q[$];
    out_t vstep_ref[$];

    // Reference model state: position of the next pixel and the image so far.
    int m_row = 0;
    int m_col = 0;
    int img [H][W];

    // Monitor: log every output event with the cycle it was seen in.
    always @(negedge clk) begin
        if (bus.grad_valid === 1'b1)
            obs_q.push_back({32'(cyc), bus.sobel_x, bus.sobel_y, bus.grad_addr});
        if (bus.frame_done === 1'b1)
            fd_obs_q.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // One input cycle; accepted pixels are pushed through the model.
    task automatic drive(input bit v, input logic [7:0] p, input bit s);
        int gx, gy, r, c;
        @(negedge clk);
        bus.pix_valid = v;
        bus.pix_in    = p;
        bus.sof       = s;
        if (v) begin
            if (s) begin
                m_row = 0;
                m_col = 0;
            end
            r = m_row;
            c = m_col;
            img[r][c] = int'(p);
            if (r >= 2 && c >= 2) begin
                gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
                   - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
                gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
                   - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
                exp_q.push_back({32'(cyc + 2), 9'(gx >>> 2), 9'(gy >>> 2),
                                 PW'((r - 1) * W + (c - 1))});
            end
            if (r == H - 1 && c == W - 1)
                fd_exp_q.push_back(cyc + 1);
            if (c == W - 1) begin
                m_col = 0;
                m_row = (r == H - 1) ? 0 : r + 1;
            end else begin
                m_col = c + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic clear_q();
        obs_q.delete();
        exp_q.delete();
        fd_obs_q.delete();
        fd_exp_q.delete();
    endtask

    function automatic logic [7:0] pat(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'd100;
            1:       return (c < 4) ? 8'd0 : 8'd255;
            2:       return (c < 4) ? 8'd255 : 8'd0;
            3:       return (r < 3) ? 8'd255 : 8'd0;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic send_frame(input int kind, input int gap_pct);
        for (int k = 0; k < W * H; k++) begin
            while ($urandom_range(99) < gap_pct) drive(1'b0, 8'h00, 1'b0);
            drive(1'b1, pat(kind, k / W, k % W), k == 0);
        end
    endtask

    // Reset for one edge; pixels due after that edge are dropped from the model.
    task automatic apply_reset(input bit with_pix, output int rc);
        out_t keep[$];
        int   fkeep[$];
        @(negedge clk);
        reset         = 1'b1;
        bus.pix_valid = with_pix;
        bus.pix_in    = 8'($urandom);
        bus.sof       = 1'b0;
        rc = cyc;
        @(negedge clk);
        reset         = 1'b0;
        bus.pix_valid = 1'b0;
        foreach (exp_q[i]) if (int'(exp_q[i].t) <= rc) keep.push_back(exp_q[i]);
        foreach (fd_exp_q[i]) if (fd_exp_q[i] <= rc) fkeep.push_back(fd_exp_q[i]);
        exp_q    = keep;
        fd_exp_q = fkeep;
        m_row = 0;
        m_col = 0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset         = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'hA5;
        bus.sof       = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.grad_valid !== 1'b0) begin errors++; $display("FAIL reset_grad_valid actual=%b required=0", bus.grad_valid); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done actual=%b required=0", bus.frame_done); end
        checks++; if (bus.sobel_x !== 9'd0) begin errors++; $display("FAIL reset_sobel_x actual=%0d required=0", bus.sobel_x); end
        checks++; if (bus.sobel_y !== 9'd0) begin errors++; $display("FAIL reset_sobel_y actual=%0d required=0", bus.sobel_y); end
        checks++; if (bus.grad_addr !== '0) begin errors++; $display("FAIL reset_grad_addr actual=%0d required=0", bus.grad_addr); end
        reset         = 1'b0;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        idle(4);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_no_output actual=%0d required=0", obs_q.size()); end
        checks++; if (fd_obs_q.size() != 0) begin errors++; $display("FAIL reset_no_frame_done actual=%0d required=0", fd_obs_q.size()); end
        clear_q();
    endtask

    task automatic test_flat();
        int ea;
        clear_q();
        send_frame(0, 0);
        idle(4);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL flat_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL flat_out[%0d] actual t=%0d x=%0d y=%0d a=%0d required t=%0d x=%0d y=%0d a=%0d", i, obs_q[i].t, $signed(obs_q[i].x), $signed(obs_q[i].y), obs_q[i].a, exp_q[i].t, $signed(exp_q[i].x), $signed(exp_q[i].y), exp_q[i].a); end
        end
        checks++; if (obs_q.size() != 24) begin errors++; $display("FAIL flat_24 actual=%0d required=24", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            ea = (i / 6 + 1) * W + (i % 6 + 1);
            checks++;
            if (obs_q[i].x !== 9'd0 || obs_q[i].y !== 9'd0 || obs_q[i].a !== PW'(ea)) begin errors++; $display("FAIL flat_value[%0d] actual x=%0d y=%0d a=%0d required x=0 y=0 a=%0d", i, $signed(obs_q[i].x), $signed(obs_q[i].y), obs_q[i].a, ea); end
        end
        checks++; if (fd_obs_q.size() != 1 || fd_exp_q.size() != 1 || fd_obs_q[0] != fd_exp_q[0]) begin errors++; $display("FAIL flat_frame_done actual n=%0d required n=1 at %0d", fd_obs_q.size(), (fd_exp_q.size() > 0) ? fd_exp_q[0] : -1); end
    endtask

    task automatic test_vstep();
        logic signed [8:0] ex;
        for (int pol = 0; pol < 2; pol++) begin
            clear_q();
            send_frame(1 + pol, 0);
            idle(4);
            checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL vstep%0d_count actual=%0d required=%0d", pol, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL vstep%0d_out[%0d] actual t=%0d x=%0d y=%0d a=%0d required t=%0d x=%0d y=%0d a=%0d", pol, i, obs_q[i].t, $signed(obs_q[i].x), $signed(obs_q[i].y), obs_q[i].a, exp_q[i].t, $signed(exp_q[i].x), $signed(exp_q[i].y), exp_q[i].a); end
            end
            for (int i = 0; i < obs_q.size(); i++) begin
                ex = (obs_q[i].a % W == 3 || obs_q[i].a % W == 4) ? ((pol == 0) ? 9'sd255 : -9'sd255) : 9'sd0;
                checks++;
                if (obs_q[i].x !== ex || obs_q[i].y !== 9'd0) begin errors++; $display("FAIL vstep%0d_value[%0d] actual x=%0d y=%0d required x=%0d y=0", pol, i, $signed(obs_q[i].x), $signed(obs_q[i].y), ex); end
            end
            if (pol == 0) vstep_ref = obs_q;
        end
    endtask

    task automatic test_hstep();
        logic signed [8:0] ey;
        clear_q();
        send_frame(3, 0);
        idle(4);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL hstep_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL hstep_out[%0d] actual t=%0d x=%0d y=%0d a=%0d required t=%0d x=%0d y=%0d a=%0d", i, obs_q[i].t, $signed(obs_q[i].x), $signed(obs_q[i].y), obs_q[i].a, exp_q[i].t, $signed(exp_q[i].x), $signed(exp_q[i].y), exp_q[i].a); end
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            ey = (obs_q[i].a / W == 2 || obs_q[i].a / W == 3) ? -9'sd255 : 9'sd0;
            checks++;
            if (obs_q[i].y !== ey || obs_q[i].x !== 9'd0) begin errors++; $display("FAIL hstep_value[%0d] actual x=%0d y=%0d required x=0 y=%0d", i, $signed(obs_q[i].x), $signed(obs_q[i].y), ey); end
        end
    endtask

    task automatic test_stall();
        clear_q();
        send_frame(1, 35);
        idle(4);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_out[%0d] actual t=%0d x=%0d y=%0d a=%0d required t=%0d x=%0d y=%0d a=%0d", i, obs_q[i].t, $signed(obs_q[i].x), $signed(obs_q[i].y), obs_q[i].a, exp_q[i].t, $signed(exp_q[i].x), $signed(exp_q[i].y), exp_q[i].a); end
        end
        checks++; if (obs_q.size() != vstep_ref.size()) begin errors++; $display("FAIL stall_vs_gapless_count actual=%0d required=%0d", obs_q.size(), vstep_ref.size()); end
        for (int i = 0; i < obs_q.size() && i < vstep_ref.size(); i++) begin
            checks++;
            if (obs_q[i].x !== vstep_ref[i].x || obs_q[i].y !== vstep_ref[i].y || obs_q[i].a !== vstep_ref[i].a) begin errors++; $display("FAIL stall_vs_gapless[%0d] actual x=%0d a=%0d required x=%0d a=%0d", i, $signed(obs_q[i].x), obs_q[i].a, $signed(vstep_ref[i].x), vstep_ref[i].a); end
        end
    endtask

    task automatic test_resync();
        int rs, n_new, first_a;
        // Abort a frame after 19 pixels by re-sending sof on the 20th.
        clear_q();
        for (int k = 0; k < 19; k++) drive(1'b1, 8'($urandom), k == 0);
        rs = cyc + 1;
        send_frame(0, 0);
        idle(4);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL resync_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL resync_out[%0d] actual t=%0d x=%0d y=%0d a=%0d required t=%0d x=%0d y=%0d a=%0d", i, obs_q[i].t, $signed(obs_q[i].x), $signed(obs_q[i].y), obs_q[i].a, exp_q[i].t, $signed(exp_q[i].x), $signed(exp_q[i].y), exp_q[i].a); end
        end
        n_new   = 0;
        first_a = -1;
        foreach (obs_q[i]) if (int'(obs_q[i].t) >= rs + 2) begin
            if (n_new == 0) first_a = int'(obs_q[i].a);
            n_new++;
        end
        checks++; if (n_new != 24 || first_a != 9) begin errors++; $display("FAIL resync_new_frame actual n=%0d first=%0d required n=24 first=9", n_new, first_a); end
        checks++; if (fd_obs_q.size() != 1) begin errors++; $display("FAIL resync_frame_done actual=%0d required=1", fd_obs_q.size()); end

        // sof landing exactly on the frame-end position suppresses frame_done.
        clear_q();
        for (int k = 0; k < W * H - 1; k++) drive(1'b1, 8'($urandom), k == 0);
        drive(1'b1, 8'($urandom), 1'b1);
        for (int k = 1; k < W * H; k++) drive(1'b1, 8'($urandom), 1'b0);
        idle(4);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL sof_end_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL sof_end_out[%0d] actual t=%0d x=%0d y=%0d a=%0d required t=%0d x=%0d y=%0d a=%0d", i, obs_q[i].t, $signed(obs_q[i].x), $signed(obs_q[i].y), obs_q[i].a, exp_q[i].t, $signed(exp_q[i].x), $signed(exp_q[i].y), exp_q[i].a); end
        end
        checks++; if (fd_obs_q.size() != 1 || fd_exp_q.size() != 1 || fd_obs_q[0] != fd_exp_q[0]) begin errors++; $display("FAIL sof_end_frame_done actual n=%0d required n=1", fd_obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        int rc, n_after, first_a;
        clear_q();
        for (int k = 0; k < 30; k++) drive(1'b1, 8'($urandom), k == 0);
        apply_reset(1'b1, rc);
        checks++; if (bus.grad_valid !== 1'b0 || bus.frame_done !== 1'b0) begin errors++; $display("FAIL midreset_flags actual gv=%b fd=%b required 0 0", bus.grad_valid, bus.frame_done); end
        checks++; if (bus.sobel_x !== 9'd0 || bus.sobel_y !== 9'd0 || bus.grad_addr !== '0) begin errors++; $display("FAIL midreset_data actual x=%0d y=%0d a=%0d required 0 0 0", $signed(bus.sobel_x), $signed(bus.sobel_y), bus.grad_addr); end
        // New frame without sof: counters alone must restart at (0,0).
        for (int k = 0; k < W * H; k++) drive(1'b1, pat(0, 0, 0), 1'b0);
        idle(4);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midreset_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_out[%0d] actual t=%0d x=%0d y=%0d a=%0d required t=%0d x=%0d y=%0d a=%0d", i, obs_q[i].t, $signed(obs_q[i].x), $signed(obs_q[i].y), obs_q[i].a, exp_q[i].t, $signed(exp_q[i].x), $signed(exp_q[i].y), exp_q[i].a); end
        end
        n_after = 0;
        first_a = -1;
        foreach (obs_q[i]) if (int'(obs_q[i].t) > rc) begin
            if (n_after == 0) first_a = int'(obs_q[i].a);
            n_after++;
        end
        checks++; if (n_after != 24 || first_a != 9) begin errors++; $display("FAIL midreset_new_frame actual n=%0d first=%0d required n=24 first=9", n_after, first_a); end
        checks++; if (fd_obs_q.size() != 1) begin errors++; $display("FAIL midreset_frame_done actual=%0d required=1", fd_obs_q.size()); end
    endtask

    task automatic test_random();
        clear_q();
        send_frame(4, 20);
        send_frame(4, 0);
        send_frame(4, 50);
        idle(4);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_out[%0d] actual t=%0d x=%0d y=%0d a=%0d required t=%0d x=%0d y=%0d a=%0d", i, obs_q[i].t, $signed(obs_q[i].x), $signed(obs_q[i].y), obs_q[i].a, exp_q[i].t, $signed(exp_q[i].x), $signed(exp_q[i].y), exp_q[i].a); end
        end
        checks++; if (fd_obs_q.size() != fd_exp_q.size()) begin errors++; $display("FAIL random_frame_done_count actual=%0d required=%0d", fd_obs_q.size(), fd_exp_q.size()); end
        for (int i = 0; i < fd_obs_q.size() && i < fd_exp_q.size(); i++) begin
            checks++;
            if (fd_obs_q[i] != fd_exp_q[i]) begin errors++; $display("FAIL random_frame_done[%0d] actual=%0d required=%0d", i, fd_obs_q[i], fd_exp_q[i]); end
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_in    = 8'h00;
        bus.sof       = 1'b0;
        test_reset();
        test_flat();
        test_vstep();
        test_hstep();
        test_stall();
        test_resync();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
